// File: rtl/nn_fixed_pkg.sv
// nn_fixed_pkg: fixed-point defaults, neuron FSM states and the saturating adder
// Shared by neuron_mac_stream and neuron_lane_mul.
package nn_fixed_pkg;
    localparam int WGT_W_D = 19;
    localparam int PIX_W_D = 10;
    localparam int ACC_W_D = 26;
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;
    // Add two signed values and clamp the sum to a w-bit two's complement range.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
        logic signed [63:0] s, mx, mn;
        s  = a + b;
        mx = (64'sd1 <<< (w - 1)) - 64'sd1;
        mn = -mx - 64'sd1;
        return s > mx ? mx : s < mn ? mn : s;
    endfunction
endpackage

// File: rtl/neuron_lane_mul.sv
// neuron_lane_mul: one lane of signed weight x unsigned pixel, realigned and registered
// Ports: clk, rst (sync, active high), en (load product), wgt (signed weight),
//        pix (unsigned pixel), prod (registered product >>> FRAC_SH).
module neuron_lane_mul import nn_fixed_pkg::*; #(
    parameter int WGT_W   = WGT_W_D,
    parameter int PIX_W   = PIX_W_D,
    parameter int FRAC_SH = 9
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [WGT_W-1:0]               wgt,
    input  logic [PIX_W-1:0]               pix,
    output logic signed [WGT_W+PIX_W:0]    prod
);
    localparam int PW = WGT_W + PIX_W + 1;
    logic signed [PW-1:0] full;
    // Pixel gets a zero sign bit so it multiplies as a non-negative signed value.
    always_comb full = PW'($signed(wgt)) * PW'($signed({1'b0, pix}));
    always_ff @(posedge clk) begin
        if (rst) prod <= '0;
        else if (en) prod <= full >>> FRAC_SH;
    end
endmodule

// File: rtl/neuron_mac_stream.sv
// neuron_mac_stream: streaming saturated dot-product neuron (LANES products per beat)
// Ports: clk, rst (sync, active high);
//        s_valid/s_ready/s_wgt/s_pix/s_last - operand beat stream, lane k at [k*W +: W];
//        m_valid/m_ready/m_result          - saturated dot product handshake;
//        m_sat     - a clamp happened somewhere in this vector;
//        m_len_err - s_last did not coincide with beat N_IN/LANES.
module neuron_mac_stream import nn_fixed_pkg::*; #(
    parameter int N_IN    = 785,
    parameter int LANES   = 1,
    parameter int WGT_W   = WGT_W_D,
    parameter int PIX_W   = PIX_W_D,
    parameter int ACC_W   = ACC_W_D,
    parameter int FRAC_SH = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [LANES*WGT_W-1:0]   s_wgt,
    input  logic [LANES*PIX_W-1:0]   s_pix,
    input  logic                     s_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [ACC_W-1:0]         m_result,
    output logic                     m_sat,
    output logic                     m_len_err
);
    localparam int BEATS = N_IN / LANES;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam int PW    = WGT_W + PIX_W + 1;
    localparam int SW    = PW + $clog2(LANES) + 1;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic fire, done, clr, v1, v2, sat, len_err, sat_hit;
    logic signed [PW-1:0] prod [LANES];
    logic signed [SW-1:0] tree, tree_q;
    logic signed [ACC_W-1:0] acc;
    logic signed [63:0] raw, sum_sat;
    assign s_ready   = !rst && (state == IDLE || state == ACCUM);
    assign fire      = s_valid && s_ready;
    assign cnt_nx    = cnt + CNT_W'(1);
    // A vector ends on s_last or, if s_last never comes, on the last legal beat.
    assign done      = s_last || cnt_nx == CNT_W'(BEATS);
    assign clr       = state == OUT && m_ready;
    assign m_valid   = state == OUT;
    assign m_result  = acc;
    assign m_sat     = sat;
    assign m_len_err = len_err;
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        neuron_lane_mul #(.WGT_W(WGT_W), .PIX_W(PIX_W), .FRAC_SH(FRAC_SH)) u_mul (
            .clk  (clk),
            .rst  (rst),
            .en   (fire),
            .wgt  (s_wgt[i*WGT_W +: WGT_W]),
            .pix  (s_pix[i*PIX_W +: PIX_W]),
            .prod (prod[i])
        );
    end
    always_comb begin
        tree = '0;
        for (int k = 0; k < LANES; k++) tree = tree + SW'(prod[k]);
    end
    always_comb begin
        raw     = 64'(acc) + 64'(tree_q);
        sum_sat = sat_add(64'(acc), 64'(tree_q), ACC_W);
        sat_hit = sum_sat != raw;
    end
    // DRAIN waits until both pipe stages are empty so the result is final on OUT entry.
    always_comb state_nx = fire ? (done ? DRAIN : ACCUM)
                         : (state == DRAIN && !v1 && !v2) ? OUT
                         : clr ? IDLE : state;
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            tree_q  <= '0;
            acc     <= '0;
            sat     <= 1'b0;
            len_err <= 1'b0;
        end else begin
            state <= state_nx;
            v1    <= fire;
            v2    <= v1;
            if (v1) tree_q <= tree;
            if (clr) begin
                acc     <= '0;
                sat     <= 1'b0;
                len_err <= 1'b0;
                cnt     <= '0;
            end else begin
                if (v2) begin
                    acc <= ACC_W'(sum_sat);
                    sat <= sat | sat_hit;
                end
                if (fire) begin
                    cnt     <= cnt_nx;
                    len_err <= len_err | (s_last != (cnt_nx == CNT_W'(BEATS)));
                end
            end
        end
    end
endmodule

// File: tb/tb_neuron_mac_stream.sv
// tb_neuron_mac_stream: scoreboard bench for two neuron configurations
module tb_neuron_mac_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int checks = 0, errors = 0;

    typedef struct {longint res; bit sat; bit len;} exp_t;
    exp_t qa[$], qb[$];

    logic a_valid = 0, a_last = 0, a_mready = 1;
    logic [18:0] a_wgt = '0;
    logic [9:0] a_pix = '0;
    logic a_ready, a_mvalid, a_sat, a_len;
    logic [11:0] a_result;

    logic b_valid = 0, b_last = 0, b_mready = 1;
    logic [75:0] b_wgt = '0;
    logic [39:0] b_pix = '0;
    logic b_ready, b_mvalid, b_sat, b_len;
    logic [25:0] b_result;

    neuron_mac_stream #(.N_IN(4), .LANES(1), .WGT_W(19), .PIX_W(10), .ACC_W(12), .FRAC_SH(9)) dut_a (
        .clk(clk), .rst(rst), .s_valid(a_valid), .s_ready(a_ready), .s_wgt(a_wgt), .s_pix(a_pix),
        .s_last(a_last), .m_valid(a_mvalid), .m_ready(a_mready), .m_result(a_result),
        .m_sat(a_sat), .m_len_err(a_len));

    neuron_mac_stream #(.N_IN(8), .LANES(4), .WGT_W(19), .PIX_W(10), .ACC_W(26), .FRAC_SH(9)) dut_b (
        .clk(clk), .rst(rst), .s_valid(b_valid), .s_ready(b_ready), .s_wgt(b_wgt), .s_pix(b_pix),
        .s_last(b_last), .m_valid(b_mvalid), .m_ready(b_mready), .m_result(b_result),
        .m_sat(b_sat), .m_len_err(b_len));

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sat_w(input longint v, input int w);
        longint mx = (longint'(1) << (w - 1)) - 1;
        return v > mx ? mx : v < -mx - 1 ? -mx - 1 : v;
    endfunction

    longint ma_acc = 0, mb_acc = 0;
    bit ma_sat = 0, mb_sat = 0;
    int ma_cnt = 0, mb_cnt = 0;
    int a_last_cyc = 0, b_last_cyc = 0;

    task automatic send_a(input int w, input int p, input bit last);
        bit got = 0;
        longint v;
        a_valid = 1; a_wgt = 19'(w); a_pix = 10'(p); a_last = last;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = a_ready;
        end
        check("a_accept", longint'(got), 1);
        @(posedge clk); #1;
        a_last_cyc = cyc; a_valid = 0; a_last = 0;
        ma_cnt++;
        v = ma_acc + ((longint'(w) * p) >>> 9);
        ma_acc = sat_w(v, 12);
        ma_sat |= ma_acc != v;
        if (last || ma_cnt == 4) begin
            qa.push_back('{ma_acc, ma_sat, last != (ma_cnt == 4)});
            ma_acc = 0; ma_sat = 0; ma_cnt = 0;
        end
    endtask

    task automatic send_b(input int w, input int p, input bit last, input int gap);
        bit got = 0;
        longint v;
        logic [18:0] w19;
        logic [9:0] p10;
        w19 = 19'(w); p10 = 10'(p);
        if (gap > 0) begin
            b_valid = 0;
            repeat (gap) @(posedge clk);
            #1;
        end
        b_valid = 1; b_wgt = {4{w19}}; b_pix = {4{p10}}; b_last = last;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = b_ready;
        end
        check("b_accept", longint'(got), 1);
        @(posedge clk); #1;
        b_last_cyc = cyc; b_valid = 0; b_last = 0;
        mb_cnt++;
        v = mb_acc + 4 * ((longint'(w) * p) >>> 9);
        mb_acc = sat_w(v, 26);
        mb_sat |= mb_acc != v;
        if (last || mb_cnt == 2) begin
            qb.push_back('{mb_acc, mb_sat, last != (mb_cnt == 2)});
            mb_acc = 0; mb_sat = 0; mb_cnt = 0;
        end
    endtask

    task automatic wait_a_empty();
        for (int i = 0; i < 40 && qa.size() != 0; i++) @(posedge clk);
        #1;
        check("a_drain", qa.size(), 0);
    endtask

    task automatic wait_b_empty();
        for (int i = 0; i < 40 && qb.size() != 0; i++) @(posedge clk);
        #1;
        check("b_drain", qb.size(), 0);
    endtask

    bit a_mv_q = 0, b_mv_q = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (a_mvalid && !a_mv_q) check("a_latency", cyc - a_last_cyc, 3);
            if (a_mvalid && a_mready) begin
                exp_t e;
                if (qa.size() == 0) check("a_unexpected_valid", longint'(a_mvalid), 0);
                else begin
                    e = qa.pop_front();
                    check("a_result", longint'($signed(a_result)), e.res);
                    check("a_sat", longint'(a_sat), longint'(e.sat));
                    check("a_len_err", longint'(a_len), longint'(e.len));
                end
            end
            if (b_mvalid && !b_mv_q) check("b_latency", cyc - b_last_cyc, 3);
            if (b_mvalid && b_mready) begin
                exp_t e;
                if (qb.size() == 0) check("b_unexpected_valid", longint'(b_mvalid), 0);
                else begin
                    e = qb.pop_front();
                    check("b_result", longint'($signed(b_result)), e.res);
                    check("b_sat", longint'(b_sat), longint'(e.sat));
                    check("b_len_err", longint'(b_len), longint'(e.len));
                end
            end
        end
        a_mv_q = a_mvalid;
        b_mv_q = b_mvalid;
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_a_ready", longint'(a_ready), 0);
        check("rst_b_ready", longint'(b_ready), 0);
        check("rst_a_mvalid", longint'(a_mvalid), 0);
        check("rst_a_result", longint'(a_result), 0);
        check("rst_a_sat", longint'(a_sat), 0);
        check("rst_a_len", longint'(a_len), 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("post_rst_a_ready", longint'(a_ready), 1);
        check("post_rst_b_ready", longint'(b_ready), 1);
        @(posedge clk); #1;
        // basic dot product: 1+2+3+4
        send_a(512, 1, 0); send_a(1024, 1, 0); send_a(1536, 1, 0); send_a(2048, 1, 1);
        wait_a_empty();
        // mixed signs, floor shifts, negative clamp
        send_a(-1000, 3, 0); send_a(700, 10, 0); send_a(100000, 1, 0); send_a(-262144, 1023, 1);
        wait_a_empty();
        // positive clamp then a clean zero vector clears the sticky flag
        for (int i = 0; i < 4; i++) send_a(262143, 1023, i == 3);
        wait_a_empty();
        for (int i = 0; i < 4; i++) send_a(0, 0, i == 3);
        wait_a_empty();
        // early s_last
        send_a(512, 5, 0); send_a(512, 5, 1);
        wait_a_empty();
        // missing s_last: forced termination
        for (int i = 0; i < 4; i++) send_a(512, 3, 0);
        @(negedge clk);
        check("a_ready_after_force", longint'(a_ready), 0);
        wait_a_empty();
        // consumer stall
        a_mready = 0;
        for (int i = 0; i < 4; i++) send_a(1024, 3, i == 3);
        for (int i = 0; i < 20 && !a_mvalid; i++) @(negedge clk);
        check("a_stall_valid", longint'(a_mvalid), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("a_stall_hold_valid", longint'(a_mvalid), 1);
            check("a_stall_hold_result", longint'($signed(a_result)), 24);
            check("a_stall_ready", longint'(a_ready), 0);
        end
        @(posedge clk); #1;
        a_mready = 1;
        wait_a_empty();
        send_a(512, 2, 0); send_a(512, 2, 0); send_a(512, 2, 0); send_a(512, 2, 1);
        wait_a_empty();
        // reset in the middle of a vector
        send_a(2048, 1, 0); send_a(2048, 1, 0);
        rst = 1;
        @(negedge clk);
        check("midrst_a_ready", longint'(a_ready), 0);
        check("midrst_a_mvalid", longint'(a_mvalid), 0);
        @(posedge clk); #1;
        rst = 0;
        ma_acc = 0; ma_sat = 0; ma_cnt = 0;
        repeat (5) @(posedge clk);
        #1;
        send_a(512, 1, 0); send_a(1024, 1, 0); send_a(1536, 1, 0); send_a(2048, 1, 1);
        wait_a_empty();
        // four lanes, two beats, then the same vector with random gaps
        send_b(-512, 2, 0, 0); send_b(-512, 2, 1, 0);
        wait_b_empty();
        send_b(-512, 2, 0, int'($urandom_range(1, 3))); send_b(-512, 2, 1, int'($urandom_range(1, 3)));
        wait_b_empty();
        send_b(3000, 700, 0, int'($urandom_range(0, 3))); send_b(-4000, 5, 1, int'($urandom_range(0, 3)));
        wait_b_empty();
        repeat (5) @(posedge clk);
        check("a_queue_final", qa.size(), 0);
        check("b_queue_final", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
